driver_cmd_issuer: RTL and testbench
====================================

# driver_cmd_issuer

Command front-end that feeds one `driver_core` through its asynchronous configuration inputs (the `*_a` signals) in the `clock_a` domain. It accepts decoded host commands over a valid/ready handshake and drives the matching address and data buses. It then issues the active-low write strobes with enforced setup, pulse and hold windows, so that `driver_core`'s two-flop synchronizers on `clock` capture each write exactly once. Level controls (`output_active_a`, `inverter_select_a`) are registered here and held until changed.

## Interface
- `MEM_ADDRESS_LENGTH`, 6: width of address, row, column and select-address buses.
- `SETUP_CYCLES`, 2: cycles the buses are stable before the strobe falls; minimum 1, a value of 0 behaves as 1.
- `PULSE_CYCLES`, 4: strobe-low width in cycles; minimum 1, a value of 0 behaves as 1.
- `HOLD_CYCLES`, 2: cycles the buses stay stable after the strobe rises; minimum 1, a value of 0 behaves as 1.
- `clock_a`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  command type: 0 WR_MEM, 1 WR_DOT, 2 WR_SEL, 3 SET_CTRL.
- `cmd_addr`  in  MEM_ADDRESS_LENGTH  memory address for WR_MEM and WR_DOT; column address for WR_SEL.
- `cmd_row`, `cmd_col`  in  MEM_ADDRESS_LENGTH each  row/column select for WR_DOT.
- `cmd_mask`  in  3  `mask_select` value for WR_DOT.
- `cmd_data`  in  16  data word for WR_MEM.
- `cmd_flag`  in  2  bit 0: `row_col_select` for WR_SEL, `output_active` for SET_CTRL; bit 1: `inverter_select` for SET_CTRL.
- `busy`  out  1  high whenever the FSM is not IDLE.
- Outputs, named to match `driver_core` inputs: `mask_select_a`[3], `mem_address_a`, `row_select_a`, `col_select_a`, `mem_sel_col_address_a` (MEM_ADDRESS_LENGTH each), `data_in_a`[16], `row_col_select_a`, `output_active_a`, `inverter_select_a`, and the active-low strobes `mem_write_n_a`, `mem_dot_write_n_a`, `mem_sel_write_n_a`.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Accepting any WR_* command in IDLE:
  - Latch the command's fields onto their output registers on the accepting edge.
  - Select the strobe: WR_MEM→`mem_write_n_a`, WR_DOT→`mem_dot_write_n_a`, WR_SEL→`mem_sel_write_n_a`.
  - Move to SETUP.
- Each of SETUP, STROBE and HOLD lasts its parameter's cycle count, tracked by one shared 8-bit down-counter; then SETUP→STROBE→HOLD→IDLE.
- In STROBE only the selected strobe is low; the other two stay high.
- SET_CTRL:
  - Updates `output_active_a` and `inverter_select_a` on the accepting edge.
  - Issues no strobe and stays in IDLE.
- Output fields not used by the current op keep their prior values; only the op's own fields are overwritten.
- Address, data and select buses never change while the FSM is outside IDLE.
- Reset (asynchronous, including mid-operation):
  - FSM goes to IDLE.
  - All three strobes go high.
  - All buses, `mask_select_a`, `row_col_select_a`, `output_active_a` and `inverter_select_a` go to 0.
  - `busy` goes to 0.

## Timing
- Without FIFO, `cmd_ready = (state == IDLE)`.
- WR_* accepted at edge N:
  - Buses valid after edge N.
  - Strobe falls after edge N+SETUP_CYCLES and rises after edge N+SETUP_CYCLES+PULSE_CYCLES.
  - FSM returns to IDLE after edge N+SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES; `cmd_ready` is high in that cycle.
- Defaults give a 9-cycle occupancy per write.
- SET_CTRL: 1-cycle occupancy, output change visible the cycle after acceptance, back-to-back SET_CTRL at full rate.
- `cmd_valid` low during a transfer has no effect. Commands are never dropped or duplicated.

## Configuration
- `DRIVER_CMD_FIFO_EN` defined: a 4-entry command FIFO sits in front of the FSM.
  - `cmd_ready = !fifo_full`; the FSM pops from the FIFO head when IDLE and the FIFO is non-empty.
  - Simultaneous push and pop when full is refused (ready low).
  - Pointers wrap modulo 4; reset empties the FIFO.
  - Adds 1 cycle of latency from acceptance to SETUP entry.
- `DRIVER_CMD_FIFO_EN` undefined: no FIFO; behaviour is as in Timing above.

## Structure
- Package `driver_cmd_pkg`:
  - Opcode localparams `OP_WR_MEM`, `OP_WR_DOT`, `OP_WR_SEL`, `OP_SET_CTRL`.
  - State encodings.
  - Counter width, 8.
- One sub-module, `driver_cmd_fifo`, parameterized width and depth 4, instantiated only under the macro.

## Test plan
- After reset release: all strobes = 1, all buses = 0, `cmd_ready` = 1, `busy` = 0.
- WR_MEM, addr=0x2A, data=0xBEEF, default params → buses set after the accepting edge; `mem_write_n_a` low for exactly 4 cycles beginning 2 cycles after acceptance; the other strobes never low; `cmd_ready` high again 8 cycles after acceptance.
- WR_DOT (row=3, col=5, mask=3'b101) immediately followed by WR_SEL (addr=7, flag=1) → second accepted only when the first reaches IDLE; `mem_dot_write_n_a` pulse, then `mem_sel_write_n_a` pulse; `row_select_a`=3 persists through WR_SEL.
- SET_CTRL with flag=2'b11, then flag=2'b01 on consecutive cycles → `output_active_a`=1 throughout; `inverter_select_a` goes 1, then 0; no strobe activity.
- `reset_n` asserted in the 2nd STROBE cycle → strobe high immediately; after release the FSM is IDLE and the aborted command is not re-issued.
- With `DRIVER_CMD_FIFO_EN`: push 5 WR_MEM commands back-to-back → `cmd_ready` low while 4 are held; all 5 strobes issued in order with no gap beyond the 1-cycle pop latency.

Source files
------------

// File: rtl/driver_cmd_pkg.sv
// Shared opcodes, FSM state encoding and window-counter helpers for driver_cmd_issuer.
package driver_cmd_pkg;

  localparam logic [1:0] OP_WR_MEM   = 2'd0;
  localparam logic [1:0] OP_WR_DOT   = 2'd1;
  localparam logic [1:0] OP_WR_SEL   = 2'd2;
  localparam logic [1:0] OP_SET_CTRL = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // A window of N cycles loads N-1; zero-length windows are stretched to one cycle.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    int eff;
    eff = (cycles < 1) ? 1 : cycles;
    return CNT_W'(eff - 1);
  endfunction

endpackage

// File: rtl/driver_cmd_fifo.sv
// Small synchronous command FIFO (power-of-two depth) placed in front of the issuer FSM.
module driver_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; the count gates every read, so stale entries are never observed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/driver_cmd_issuer.sv
// Host command front-end for driver_core: drives config buses and timed write strobes.
// Optional DRIVER_CMD_FIFO_EN adds a 4-entry command FIFO ahead of the FSM.
module driver_cmd_issuer
  import driver_cmd_pkg::*;
#(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int SETUP_CYCLES       = 2,
  parameter int PULSE_CYCLES       = 4,
  parameter int HOLD_CYCLES        = 2
) (
  input  logic                          clock_a,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_row,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_col,
  input  logic [2:0]                    cmd_mask,
  input  logic [15:0]                   cmd_data,
  input  logic [1:0]                    cmd_flag,
  output logic                          busy,
  output logic [2:0]                    mask_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_address_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address_a,
  output logic [15:0]                   data_in_a,
  output logic                          row_col_select_a,
  output logic                          output_active_a,
  output logic                          inverter_select_a,
  output logic                          mem_write_n_a,
  output logic                          mem_dot_write_n_a,
  output logic                          mem_sel_write_n_a
);

  localparam int AL = MEM_ADDRESS_LENGTH;
  localparam logic [CNT_W-1:0] LD_SETUP = cnt_load(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] LD_PULSE = cnt_load(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LD_HOLD  = cnt_load(HOLD_CYCLES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_sel;
  logic [2:0]       r_strobe_n;
  logic [2:0]       w_strobe_n_nxt;

  logic [2:0]    r_mask;
  logic [AL-1:0] r_addr;
  logic [AL-1:0] r_row;
  logic [AL-1:0] r_col;
  logic [AL-1:0] r_sel_addr;
  logic [15:0]   r_data;
  logic          r_rcs;
  logic          r_oa;
  logic          r_inv;

  // Command presented to the FSM, either straight from the port or from the FIFO head.
  logic          w_issue;
  logic [1:0]    w_iss_op;
  logic [AL-1:0] w_iss_addr;
  logic [AL-1:0] w_iss_row;
  logic [AL-1:0] w_iss_col;
  logic [2:0]    w_iss_mask;
  logic [15:0]   w_iss_data;
  logic [1:0]    w_iss_flag;

`ifdef DRIVER_CMD_FIFO_EN
  localparam int CMD_W = 2 + 3*AL + 3 + 16 + 2;

  logic [CMD_W-1:0] w_fifo_in;
  logic [CMD_W-1:0] w_fifo_out;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_fifo_push;

  assign w_fifo_in   = {cmd_op, cmd_addr, cmd_row, cmd_col, cmd_mask, cmd_data, cmd_flag};
  assign w_fifo_push = cmd_valid && !w_fifo_full;

  driver_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (4)
  ) u_cmd_fifo (
    .i_clk   (clock_a),
    .i_rst_n (reset_n),
    .i_push  (w_fifo_push),
    .i_data  (w_fifo_in),
    .i_pop   (w_issue),
    .o_data  (w_fifo_out),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign {w_iss_op, w_iss_addr, w_iss_row, w_iss_col,
          w_iss_mask, w_iss_data, w_iss_flag} = w_fifo_out;
  assign w_issue   = !w_fifo_empty && (r_state == ST_IDLE);
  assign cmd_ready = !w_fifo_full;
`else
  assign w_iss_op   = cmd_op;
  assign w_iss_addr = cmd_addr;
  assign w_iss_row  = cmd_row;
  assign w_iss_col  = cmd_col;
  assign w_iss_mask = cmd_mask;
  assign w_iss_data = cmd_data;
  assign w_iss_flag = cmd_flag;
  assign w_issue    = cmd_valid && (r_state == ST_IDLE);
  assign cmd_ready  = (r_state == ST_IDLE);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue && (w_iss_op != OP_SET_CTRL)) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = LD_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they leave the block glitch-free.
  always_comb begin
    w_strobe_n_nxt = 3'b111;
    if (w_state_nxt == ST_STROBE) begin
      case (r_sel)
        OP_WR_MEM: w_strobe_n_nxt[0] = 1'b0;
        OP_WR_DOT: w_strobe_n_nxt[1] = 1'b0;
        OP_WR_SEL: w_strobe_n_nxt[2] = 1'b0;
        default:   w_strobe_n_nxt    = 3'b111;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_a or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_strobe_n <= 3'b111;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_strobe_n <= w_strobe_n_nxt;
    end
  end

  // Only the accepted op's own fields are overwritten; all others persist.
  always_ff @(posedge clock_a or negedge reset_n) begin
    if (!reset_n) begin
      r_sel      <= OP_WR_MEM;
      r_mask     <= '0;
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_sel_addr <= '0;
      r_data     <= '0;
      r_rcs      <= 1'b0;
      r_oa       <= 1'b0;
      r_inv      <= 1'b0;
    end else if (w_issue) begin
      case (w_iss_op)
        OP_WR_MEM: begin
          r_sel  <= w_iss_op;
          r_addr <= w_iss_addr;
          r_data <= w_iss_data;
        end
        OP_WR_DOT: begin
          r_sel  <= w_iss_op;
          r_addr <= w_iss_addr;
          r_row  <= w_iss_row;
          r_col  <= w_iss_col;
          r_mask <= w_iss_mask;
        end
        OP_WR_SEL: begin
          r_sel      <= w_iss_op;
          r_sel_addr <= w_iss_addr;
          r_rcs      <= w_iss_flag[0];
        end
        default: begin
          r_oa  <= w_iss_flag[0];
          r_inv <= w_iss_flag[1];
        end
      endcase
    end
  end

  assign busy                  = (r_state != ST_IDLE);
  assign mask_select_a         = r_mask;
  assign mem_address_a         = r_addr;
  assign row_select_a          = r_row;
  assign col_select_a          = r_col;
  assign mem_sel_col_address_a = r_sel_addr;
  assign data_in_a             = r_data;
  assign row_col_select_a      = r_rcs;
  assign output_active_a       = r_oa;
  assign inverter_select_a     = r_inv;
  assign mem_write_n_a         = r_strobe_n[0];
  assign mem_dot_write_n_a     = r_strobe_n[1];
  assign mem_sel_write_n_a     = r_strobe_n[2];

endmodule

// File: tb/tb_driver_cmd_issuer.sv
// Scoreboard bench for driver_cmd_issuer: expected strobe pulses are queued at acceptance and checked on each pulse.
module tb_driver_cmd_issuer;
  import driver_cmd_pkg::*;

  localparam int AL    = 6;
  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
`ifdef DRIVER_CMD_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AL-1:0] cmd_addr, cmd_row, cmd_col;
  logic [2:0]    cmd_mask;
  logic [15:0]   cmd_data;
  logic [1:0]    cmd_flag;
  logic          busy;
  logic [2:0]    mask_select_a;
  logic [AL-1:0] mem_address_a, row_select_a, col_select_a, mem_sel_col_address_a;
  logic [15:0]   data_in_a;
  logic          row_col_select_a, output_active_a, inverter_select_a;
  logic          mem_write_n_a, mem_dot_write_n_a, mem_sel_write_n_a;

  driver_cmd_issuer #(
    .MEM_ADDRESS_LENGTH (AL),
    .SETUP_CYCLES       (SETUP),
    .PULSE_CYCLES       (PULSE),
    .HOLD_CYCLES        (HOLD)
  ) dut (
    .clock_a               (clk),
    .reset_n               (reset_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_addr              (cmd_addr),
    .cmd_row               (cmd_row),
    .cmd_col               (cmd_col),
    .cmd_mask              (cmd_mask),
    .cmd_data              (cmd_data),
    .cmd_flag              (cmd_flag),
    .busy                  (busy),
    .mask_select_a         (mask_select_a),
    .mem_address_a         (mem_address_a),
    .row_select_a          (row_select_a),
    .col_select_a          (col_select_a),
    .mem_sel_col_address_a (mem_sel_col_address_a),
    .data_in_a             (data_in_a),
    .row_col_select_a      (row_col_select_a),
    .output_active_a       (output_active_a),
    .inverter_select_a     (inverter_select_a),
    .mem_write_n_a         (mem_write_n_a),
    .mem_dot_write_n_a     (mem_dot_write_n_a),
    .mem_sel_write_n_a     (mem_sel_write_n_a)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]    lowmask;
    int            fall;
    logic [AL-1:0] addr, row, col, sel;
    logic [2:0]    mask;
    logic [15:0]   data;
    logic          rcs;
  } exp_t;

  exp_t q[$];

  // Reference model of the persistent bus fields and of when the FSM is next free.
  logic [AL-1:0] m_addr, m_row, m_col, m_sel;
  logic [2:0]    m_mask;
  logic [15:0]   m_data;
  logic          m_rcs;
  int            m_free;

  task automatic model_reset();
    m_addr = '0; m_row = '0; m_col = '0; m_sel = '0;
    m_mask = '0; m_data = '0; m_rcs = 1'b0; m_free = -100;
  endtask

  // Pulse monitor: sampled on the falling edge, away from the active edge.
  bit   in_pulse = 0;
  bit   ignore_pulse = 0;
  bit   allow_untracked = 0;
  int   width = 0;
  int   low_samples = 0;
  exp_t cur;

  always @(negedge clk) begin
    logic [2:0] low;
    low = ~{mem_sel_write_n_a, mem_dot_write_n_a, mem_write_n_a};
    if (low != 3'b000) low_samples++;
    if (!reset_n) begin
      in_pulse = 0;
    end else if (!in_pulse) begin
      if (low != 3'b000) begin
        in_pulse = 1;
        width    = 1;
        if (q.size() > 0) begin
          cur = q.pop_front();
          ignore_pulse = 0;
          check("strobe_sel", low, cur.lowmask);
          check("fall_cycle", cyc, cur.fall);
        end else begin
          ignore_pulse = 1;
          if (!allow_untracked) check("unexpected_strobe", low, 3'b000);
        end
      end
    end else if (low != 3'b000) begin
      width++;
      if (!ignore_pulse) check("strobe_onehot", low, cur.lowmask);
    end else begin
      in_pulse = 0;
      if (!ignore_pulse) begin
        check("pulse_width", width, PULSE);
        check("bus_addr", mem_address_a, cur.addr);
        check("bus_data", data_in_a, cur.data);
        check("bus_row", row_select_a, cur.row);
        check("bus_col", col_select_a, cur.col);
        check("bus_mask", mask_select_a, cur.mask);
        check("bus_seladdr", mem_sel_col_address_a, cur.sel);
        check("bus_rcs", row_col_select_a, cur.rcs);
      end
    end
  end

  // Drive one command from a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [AL-1:0] addr, input logic [AL-1:0] row,
                       input logic [AL-1:0] col, input logic [2:0] mask, input logic [15:0] data,
                       input logic [1:0] flag, input bit track, output int acc);
    int   g;
    int   start;
    exp_t e;
    cmd_op = op; cmd_addr = addr; cmd_row = row; cmd_col = col;
    cmd_mask = mask; cmd_data = data; cmd_flag = flag; cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", cmd_ready, 1'b1);
    acc   = cyc + 1;
    start = (acc + LAT > m_free + 1) ? acc + LAT : m_free + 1;
    case (op)
      OP_WR_MEM: begin m_addr = addr; m_data = data; end
      OP_WR_DOT: begin m_addr = addr; m_row = row; m_col = col; m_mask = mask; end
      OP_WR_SEL: begin m_sel = addr; m_rcs = flag[0]; end
      default: ;
    endcase
    if (op == OP_SET_CTRL) begin
      m_free = start;
    end else begin
      m_free = start + SETUP + PULSE + HOLD;
      e.lowmask = 3'b001 << op;
      e.fall = start + SETUP;
      e.addr = m_addr; e.row = m_row; e.col = m_col; e.sel = m_sel;
      e.mask = m_mask; e.data = m_data; e.rcs = m_rcs;
      if (track) q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || q.size() != 0 || in_pulse) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_queue", q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, g, base;
    int acc5[5];
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_row = '0;
    cmd_col = '0; cmd_mask = '0; cmd_data = '0; cmd_flag = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_strobes", {mem_sel_write_n_a, mem_dot_write_n_a, mem_write_n_a}, 3'b111);
    check("rst_addr", mem_address_a, 0);
    check("rst_data", data_in_a, 0);
    check("rst_rowcol", {row_select_a, col_select_a, mem_sel_col_address_a}, 0);
    check("rst_ctrl", {mask_select_a, row_col_select_a, output_active_a, inverter_select_a}, 0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Single WR_MEM
    issue(OP_WR_MEM, 6'h2A, 6'h0, 6'h0, 3'b000, 16'hBEEF, 2'b00, 1'b1, a1);
    cmd_valid = 1'b0;
    wait_to(a1 + LAT);
    check("mem_addr_latched", mem_address_a, 6'h2A);
    check("mem_data_latched", data_in_a, 16'hBEEF);
    check("mem_busy", busy, 1'b1);
`ifndef DRIVER_CMD_FIFO_EN
    check("mem_ready_low", cmd_ready, 1'b0);
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("ready_again", cyc - a1, 8);
`endif
    wait_idle();

    // WR_DOT then WR_SEL back-to-back
    issue(OP_WR_DOT, 6'h11, 6'd3, 6'd5, 3'b101, 16'h0, 2'b00, 1'b1, a1);
    issue(OP_WR_SEL, 6'd7, 6'h0, 6'h0, 3'b000, 16'h0, 2'b01, 1'b1, a2);
    cmd_valid = 1'b0;
`ifdef DRIVER_CMD_FIFO_EN
    check("sel_accept_gap", a2 - a1, 1);
`else
    check("sel_accept_gap", a2 - a1, 9);
`endif
    wait_idle();

    // SET_CTRL at full rate
    base = low_samples;
    issue(OP_SET_CTRL, 6'h0, 6'h0, 6'h0, 3'b000, 16'h0, 2'b11, 1'b1, a1);
`ifndef DRIVER_CMD_FIFO_EN
    check("ctrl1_oa", output_active_a, 1'b1);
    check("ctrl1_inv", inverter_select_a, 1'b1);
`endif
    issue(OP_SET_CTRL, 6'h0, 6'h0, 6'h0, 3'b000, 16'h0, 2'b01, 1'b1, a2);
    cmd_valid = 1'b0;
`ifdef DRIVER_CMD_FIFO_EN
    check("ctrl1_oa", output_active_a, 1'b1);
    check("ctrl1_inv", inverter_select_a, 1'b1);
`endif
    check("ctrl_rate", a2 - a1, 1);
    wait_to(a2 + LAT);
    check("ctrl2_oa", output_active_a, 1'b1);
    check("ctrl2_inv", inverter_select_a, 1'b0);
    check("ctrl_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("ctrl_no_strobe", low_samples - base, 0);
    check("ctrl_row_kept", row_select_a, 6'd3);

    // Reset during the 2nd STROBE cycle
    allow_untracked = 1;
    issue(OP_WR_MEM, 6'h15, 6'h0, 6'h0, 3'b000, 16'h1234, 2'b00, 1'b0, a1);
    cmd_valid = 1'b0;
    wait_to(a1 + LAT + SETUP + 1);
    check("abort_pre_low", mem_write_n_a, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("abort_strobe_high", mem_write_n_a, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", mem_address_a, 0);
    check("abort_data", data_in_a, 0);
    check("abort_ctrl", {output_active_a, inverter_select_a, row_select_a}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    allow_untracked = 0;
    base = low_samples;
    repeat (15) @(negedge clk);
    check("no_reissue", low_samples - base, 0);
    check("post_abort_busy", busy, 1'b0);
    check("post_abort_ready", cmd_ready, 1'b1);

    // Burst of five WR_MEM commands
    for (int i = 0; i < 5; i++) begin
      issue(OP_WR_MEM, AL'(i * 9 + 1), 6'h0, 6'h0, 3'b000, 16'($urandom), 2'b00, 1'b1, acc5[i]);
    end
    cmd_valid = 1'b0;
`ifdef DRIVER_CMD_FIFO_EN
    check("burst_full_ready", cmd_ready, 1'b0);
    check("burst_rate", acc5[4] - acc5[0], 4);
`else
    check("burst_gap", acc5[4] - acc5[3], 9);
`endif
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
